// File: rtl/key_tone_gen.sv
// Purpose: tracks PS/2 make/break codes for note keys and drives a square-wave tone for the held note.
// Latency: gate/held_key/note_hp update on the edge ending the data_valid cycle; first toggle note_hp edges later.
// Backpressure: none; every data_valid strobe is consumed, including back-to-back strobes.
module key_tone_gen #(
  parameter int HP_WIDTH = 21
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          data,
  input  logic                data_valid,
  input  logic [HP_WIDTH-1:0] half_period,
  output logic                tone_out,
  output logic                gate,
  output logic [7:0]          held_key,
  output logic [HP_WIDTH-1:0] note_hp
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BREAK = 1'b1
  } state_t;

  localparam logic [7:0] BREAK_CODE = 8'hF0;

  state_t              state_q, state_d;
  logic                gate_q, gate_d;
  logic                tone_q, tone_d;
  logic [7:0]          held_q, held_d;
  logic [HP_WIDTH-1:0] hp_q, hp_d;
  logic [HP_WIDTH-1:0] cnt_q, cnt_d;
  logic [HP_WIDTH-1:0] cnt_last;
  logic                capture;
  logic                release_key;

  // Scan codes of the twelve keys that play a note.
  function automatic logic is_note(input logic [7:0] b);
    case (b)
      8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35,
      8'h3C, 8'h43, 8'h44, 8'h4D, 8'h54, 8'h5B: is_note = 1'b1;
      default:                                  is_note = 1'b0;
    endcase
  endfunction

  // A half period of 0 is treated as 1, so the terminal count is 0 in both cases.
  assign cnt_last = (hp_q == '0) ? '0 : hp_q - HP_WIDTH'(1);

  // Next state: decode the byte stream, then capture, release or advance the tone counter.
  always_comb begin
    state_d     = state_q;
    gate_d      = gate_q;
    tone_d      = tone_q;
    held_d      = held_q;
    hp_d        = hp_q;
    cnt_d       = cnt_q;
    capture     = 1'b0;
    release_key = 1'b0;

    if (data_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (data == BREAK_CODE) begin
            state_d = ST_BREAK;
          end else if (is_note(data) && (!gate_q || data != held_q)) begin
            // Typematic repeats of the held key fall through and leave the phase alone.
            capture = 1'b1;
          end
        end
        ST_BREAK: begin
          if (data != BREAK_CODE) begin
            state_d = ST_IDLE;
            // Releasing some other key leaves the current note sounding.
            if (gate_q && data == held_q) release_key = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (capture) begin
      held_d = data;
      hp_d   = half_period;
      gate_d = 1'b1;
      cnt_d  = '0;
      // A key change while sounding keeps the current level so the output never glitches.
      tone_d = gate_q ? tone_q : 1'b0;
    end else if (release_key) begin
      held_d = '0;
      hp_d   = '0;
      gate_d = 1'b0;
      cnt_d  = '0;
      tone_d = 1'b0;
    end else if (gate_q) begin
      if (cnt_q == cnt_last) begin
        cnt_d  = '0;
        tone_d = ~tone_q;
      end else begin
        cnt_d  = cnt_q + HP_WIDTH'(1);
      end
    end else begin
      cnt_d  = '0;
      tone_d = 1'b0;
    end
  end

  // State and output registers; reset silences the tone immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gate_q  <= 1'b0;
      tone_q  <= 1'b0;
      held_q  <= '0;
      hp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      tone_q  <= tone_d;
      held_q  <= held_d;
      hp_q    <= hp_d;
      cnt_q   <= cnt_d;
    end
  end

  assign tone_out = tone_q;
  assign gate     = gate_q;
  assign held_key = held_q;
  assign note_hp  = hp_q;

endmodule

// File: tb/tb_key_tone_gen.sv
module tb_key_tone_gen;

  localparam int HPW = 21;

  logic           clk;
  logic           rst_n;
  logic [7:0]     data;
  logic           data_valid;
  logic [HPW-1:0] half_period;
  logic           tone_out;
  logic           gate;
  logic [7:0]     held_key;
  logic [HPW-1:0] note_hp;

  key_tone_gen #(.HP_WIDTH(HPW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data       (data),
    .data_valid (data_valid),
    .half_period(half_period),
    .tone_out   (tone_out),
    .gate       (gate),
    .held_key   (held_key),
    .note_hp    (note_hp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic           dv;
    logic [7:0]     d;
    logic [HPW-1:0] hp;
    logic           eg;
    logic           et;
    logic [7:0]     eh;
    logic [HPW-1:0] en;
  } vec_t;

  vec_t tbl[$];
  int   n_vec;
  int   n_err;

  task automatic add(input logic dv, input logic [7:0] d, input int hp,
                     input logic eg, input logic et, input logic [7:0] eh, input int en);
    vec_t v;
    v.dv = dv; v.d = d; v.hp = HPW'(hp);
    v.eg = eg; v.et = et; v.eh = eh; v.en = HPW'(en);
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic eg, input logic et,
                       input logic [7:0] eh, input logic [HPW-1:0] en);
    n_vec++;
    if (gate !== eg || tone_out !== et || held_key !== eh || note_hp !== en) begin
      n_err++;
      $display("FAIL %s: got gate=%b tone=%b held=%h hp=%0d, want gate=%b tone=%b held=%h hp=%0d",
               name, gate, tone_out, held_key, note_hp, eg, et, eh, en);
    end
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic dv, input logic [7:0] d, input logic [HPW-1:0] hp);
    @(negedge clk);
    data_valid  = dv;
    data        = d;
    half_period = hp;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    data = 8'h00;
    data_valid = 1'b0;
    half_period = '0;

    //   dv  data   hp  gate tone held   note_hp
    add(0, 8'h00, 0, 0, 0, 8'h00, 0);  // idle after reset
    add(1, 8'h15, 4, 1, 0, 8'h15, 4);  // capture
    add(0, 8'h00, 0, 1, 0, 8'h15, 4);
    add(0, 8'h00, 0, 1, 0, 8'h15, 4);
    add(0, 8'h00, 0, 1, 0, 8'h15, 4);
    add(0, 8'h00, 0, 1, 1, 8'h15, 4);  // first toggle 4 edges after capture
    add(1, 8'h15, 9, 1, 1, 8'h15, 4);  // typematic repeat ignored
    add(0, 8'h00, 0, 1, 1, 8'h15, 4);
    add(0, 8'h00, 0, 1, 1, 8'h15, 4);
    add(0, 8'h00, 0, 1, 0, 8'h15, 4);  // phase unbroken
    add(0, 8'h00, 0, 1, 0, 8'h15, 4);
    add(0, 8'h00, 0, 1, 0, 8'h15, 4);
    add(0, 8'h00, 0, 1, 0, 8'h15, 4);
    add(0, 8'h00, 0, 1, 1, 8'h15, 4);
    add(0, 8'h00, 0, 1, 1, 8'h15, 4);
    add(1, 8'h1D, 6, 1, 1, 8'h1D, 6);  // key change mid-high keeps level
    add(0, 8'h00, 0, 1, 1, 8'h1D, 6);
    add(0, 8'h00, 0, 1, 1, 8'h1D, 6);
    add(0, 8'h00, 0, 1, 1, 8'h1D, 6);
    add(0, 8'h00, 0, 1, 1, 8'h1D, 6);
    add(0, 8'h00, 0, 1, 1, 8'h1D, 6);
    add(0, 8'h00, 0, 1, 0, 8'h1D, 6);  // toggle 6 edges after change
    add(1, 8'hF0, 0, 1, 0, 8'h1D, 6);
    add(1, 8'h15, 0, 1, 0, 8'h1D, 6);  // release of other key ignored
    add(1, 8'hF0, 0, 1, 0, 8'h1D, 6);
    add(1, 8'hF0, 0, 1, 0, 8'h1D, 6);  // double F0 stays in break
    add(1, 8'h1D, 0, 0, 0, 8'h00, 0);  // release
    add(0, 8'h00, 0, 0, 0, 8'h00, 0);
    add(1, 8'hE0, 0, 0, 0, 8'h00, 0);  // extended prefix ignored
    add(1, 8'h12, 7, 0, 0, 8'h00, 0);  // non-note key ignored
    add(1, 8'h2C, 0, 1, 0, 8'h2C, 0);  // half period 0 acts as 1
    add(0, 8'h00, 0, 1, 1, 8'h2C, 0);
    add(0, 8'h00, 0, 1, 0, 8'h2C, 0);
    add(0, 8'h00, 0, 1, 1, 8'h2C, 0);
    add(1, 8'hF0, 0, 1, 0, 8'h2C, 0);
    add(1, 8'h2C, 0, 0, 0, 8'h00, 0);  // back-to-back release

    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", 1'b0, 1'b0, 8'h00, '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].dv, tbl[i].d, tbl[i].hp);
      check($sformatf("vec%0d", i), tbl[i].eg, tbl[i].et, tbl[i].eh, tbl[i].en);
    end

    // Reset mid-note, between clock edges.
    step(1'b1, 8'h15, HPW'(4));
    check("seq_capture", 1'b1, 1'b0, 8'h15, HPW'(4));
    repeat (4) step(1'b0, 8'h00, '0);
    check("seq_high", 1'b1, 1'b1, 8'h15, HPW'(4));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 1'b0, 1'b0, 8'h00, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 8'h00, '0);
      check($sformatf("post_reset%0d", k), 1'b0, 1'b0, 8'h00, '0);
    end
    step(1'b1, 8'h43, HPW'(3));
    check("fresh_make", 1'b1, 1'b0, 8'h43, HPW'(3));
    step(1'b0, 8'h00, '0);
    step(1'b0, 8'h00, '0);
    step(1'b0, 8'h00, '0);
    check("fresh_toggle", 1'b1, 1'b1, 8'h43, HPW'(3));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
